// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift ops plus iterative shift-add MUL and restoring DIV/MOD.
// Define ALU_SEQ_MULDIV_EN to build the MUL/DIV/MOD engines; without it those opcodes report err.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   alu_op,
  input  logic [W-1:0] operandA,
  input  logic [W-1:0] operandB,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic [1:0]   address,
  output logic [3:0]   flags
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_LSR = 5'b00010;
  localparam logic [4:0] OP_LSL = 5'b00011;
  localparam logic [4:0] OP_MOV = 5'b00100;
  localparam logic [4:0] OP_RSR = 5'b00101;
  localparam logic [4:0] OP_RSL = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_XOR = 5'b01100;
  localparam logic [4:0] OP_NOT = 5'b01101;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_TST = 5'b01111;
  localparam logic [4:0] OP_INC = 5'b10000;
  localparam logic [4:0] OP_DEC = 5'b10001;

  localparam logic [W-1:0] W_AMT = W'(W);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] result_q, result_d;
  logic [1:0]   address_q, address_d;
  logic [3:0]   flags_q, flags_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [W-1:0] b_eff;
  logic [W:0]   add_ext, sub_ext;
  logic         add_v, sub_v;
  logic [W-1:0] sc_val, sc_res_n;
  logic [3:0]   sc_arith, sc_flags_n;
  logic [1:0]   sc_addr_n;
  logic         sc_use_ar, sc_wr_res, sc_wr_fl, sc_err;

  function automatic logic [3:0] nz_flags(input logic [W-1:0] r);
    return {r[W-1], (r == '0), 2'b00};
  endfunction

  // INC/DEC reuse the adder/subtractor with B forced to one.
  always_comb begin
    b_eff   = (alu_op == OP_INC || alu_op == OP_DEC) ? ONE : operandB;
    add_ext = {1'b0, operandA} + {1'b0, b_eff};
    sub_ext = {1'b0, operandA} - {1'b0, b_eff};
    add_v   = (operandA[W-1] == b_eff[W-1]) && (add_ext[W-1] != operandA[W-1]);
    sub_v   = (operandA[W-1] != b_eff[W-1]) && (sub_ext[W-1] != operandA[W-1]);
  end

  // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    sc_val    = '0;
    sc_arith  = '0;
    sc_use_ar = 1'b0;
    sc_wr_res = 1'b1;
    sc_wr_fl  = 1'b1;
    sc_err    = 1'b0;
    sc_addr_n = address_q;
    case (alu_op)
      OP_ADD, OP_INC: begin
        sc_val    = add_ext[W-1:0];
        sc_arith  = {add_ext[W-1], (add_ext[W-1:0] == '0), add_ext[W], add_v};
        sc_use_ar = 1'b1;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        sc_val    = sub_ext[W-1:0];
        sc_arith  = {sub_ext[W-1], (sub_ext[W-1:0] == '0), sub_ext[W], sub_v};
        sc_use_ar = 1'b1;
        sc_wr_res = (alu_op != OP_CMP);
      end
      OP_LSR: sc_val = (operandB >= W_AMT) ? '0 : (operandA >> operandB);
      OP_LSL: sc_val = (operandB >= W_AMT) ? '0 : (operandA << operandB);
      OP_RSR: sc_val = (operandB == '0 || operandB >= W_AMT) ? operandA :
                       ((operandA >> operandB) | (operandA << (W_AMT - operandB)));
      OP_RSL: sc_val = (operandB == '0 || operandB >= W_AMT) ? operandA :
                       ((operandA << operandB) | (operandA >> (W_AMT - operandB)));
      OP_MOV: begin
        sc_val    = operandB;
        sc_addr_n = operandA[1:0];
        sc_wr_fl  = 1'b0;
      end
      OP_AND: sc_val = operandA & operandB;
      OP_OR:  sc_val = operandA | operandB;
      OP_XOR: sc_val = operandA ^ operandB;
      OP_NOT: sc_val = ~operandA;
      OP_TST: begin
        sc_val    = operandA & operandB;
        sc_wr_res = 1'b0;
      end
      default: begin
        sc_wr_res = 1'b0;
        sc_wr_fl  = 1'b0;
        sc_err    = 1'b1;
      end
    endcase
    sc_res_n   = sc_wr_res ? sc_val : result_q;
    sc_flags_n = !sc_wr_fl ? flags_q : (sc_use_ar ? sc_arith : nz_flags(sc_val));
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam logic [4:0] OP_MOD = 5'b01001;
  localparam int         CW     = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_e;

  state_e        state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [W-1:0]  opd_q, opd_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          iter_op, is_mul, div_ge;
  logic [W:0]    mul_sum, div_shift;
  logic [W-1:0]  div_diff;

  assign iter_op = (alu_op == OP_MUL) || (alu_op == OP_DIV) || (alu_op == OP_MOD);
  assign is_mul  = (op_q == OP_MUL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && iter_op) state_d = S_ITER;
      S_ITER:  if (cnt_q == CW'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // {acc, lo} is the double-width product for MUL and {remainder, quotient} for DIV/MOD.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {acc_q, lo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, opd_q});
    div_diff  = div_shift[W-1:0] - opd_q;
  end

  always_comb begin
    op_d      = op_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    address_d = address_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && iter_op) begin
          op_d  = alu_op;
          opd_d = (alu_op == OP_MUL) ? operandA : operandB;
          lo_d  = (alu_op == OP_MUL) ? operandB : operandA;
          acc_d = '0;
          cnt_d = CW'(W);
        end else if (start) begin
          result_d  = sc_res_n;
          address_d = sc_addr_n;
          flags_d   = sc_flags_n;
          done_d    = 1'b1;
          err_d     = sc_err;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q - CW'(1);
        if (is_mul) begin
          acc_d = mul_sum[W:1];
          lo_d  = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_ge) begin
          acc_d = div_diff;
          lo_d  = {lo_q[W-2:0], 1'b1};
        end else begin
          acc_d = div_shift[W-1:0];
          lo_d  = {lo_q[W-2:0], 1'b0};
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        if (is_mul) begin
          result_d = lo_q;
          flags_d  = {lo_q[W-1], (lo_q == '0), |acc_q, 1'b0};
        end else begin
          result_d = (op_q == OP_DIV) ? lo_q : acc_q;
          flags_d  = nz_flags(result_d);
          err_d    = (opd_q == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opd_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end
`else
  always_comb begin
    result_d  = result_q;
    address_d = address_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (start) begin
      result_d  = sc_res_n;
      address_d = sc_addr_n;
      flags_d   = sc_flags_n;
      done_d    = 1'b1;
      err_d     = sc_err;
    end
  end

  assign busy = 1'b0;
`endif

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      address_q <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      result_q  <= result_d;
      address_q <= address_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign result  = result_q;
  assign address = address_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan vectors, random ops against an arithmetic model,
// busy/ignore behaviour, back-to-back issue and reset during an operation.
module tb_alu_seq;

  localparam int     W         = 16;
  localparam int     LAT_LIMIT = W + 8;
  localparam int     OBS_W     = 1 + W + 2 + 4;
  localparam longint FULL      = longint'(1) << W;
  localparam longint HALF      = FULL / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   alu_op = '0;
  logic [W-1:0] operandA = '0;
  logic [W-1:0] operandB = '0;
  logic         busy, done, err;
  logic [W-1:0] result;
  logic [1:0]   address;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_result = '0;
  logic [1:0]   m_addr   = '0;
  logic [3:0]   m_flags  = '0;
  logic         m_err    = 1'b0;
  int           m_lat    = 0;

  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [1:0]   addr;
    logic [3:0]   fl;
    logic         e;
    logic [7:0]   lat;
  } vec_t;

  alu_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_op   (alu_op),
    .operandA (operandA),
    .operandB (operandB),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .address  (address),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the architectural state.
  task automatic model(input logic [4:0] op, input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    longint a, b, sa, sb, r, s, p;
    bit c, v, legal, wr_res, wr_flags;
    a = a_in;
    b = b_in;
    if (op == 5'h10 || op == 5'h11) b = 1;
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    r = 0; s = 0; p = 0;
    c = 0; v = 0; legal = 1; wr_res = 1; wr_flags = 1;
    m_err = 1'b0;
    m_lat = 0;
    case (op)
      5'h00, 5'h10: begin
        s = sa + sb;
        r = (a + b) % FULL;
        c = (a + b) >= FULL;
        v = (s >= HALF) || (s < -HALF);
      end
      5'h01, 5'h11, 5'h0E: begin
        s = sa - sb;
        r = (a - b + FULL) % FULL;
        c = a < b;
        v = (s >= HALF) || (s < -HALF);
        wr_res = (op != 5'h0E);
      end
      5'h02: r = (b >= W) ? 0 : (a >> b);
      5'h03: r = (b >= W) ? 0 : ((a << b) % FULL);
      5'h04: begin
        r = b;
        wr_flags = 0;
        m_addr = 2'(a % 4);
      end
      5'h05: begin
        r = a;
        if (b > 0 && b < W) repeat (b) r = (r >> 1) | ((r % 2) << (W - 1));
      end
      5'h06: begin
        r = a;
        if (b > 0 && b < W) repeat (b) r = ((r << 1) % FULL) | (r >> (W - 1));
      end
`ifdef ALU_SEQ_MULDIV_EN
      5'h07: begin
        p = a * b;
        r = p % FULL;
        c = p >= FULL;
        m_lat = W + 1;
      end
      5'h08: begin
        r = (b == 0) ? FULL - 1 : a / b;
        m_err = (b == 0);
        m_lat = W + 1;
      end
      5'h09: begin
        r = (b == 0) ? a : a % b;
        m_err = (b == 0);
        m_lat = W + 1;
      end
`endif
      5'h0A: r = a & b;
      5'h0B: r = a | b;
      5'h0C: r = a ^ b;
      5'h0D: r = (FULL - 1) - a;
      5'h0F: begin
        r = a & b;
        wr_res = 0;
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      m_err = 1'b1;
    end else begin
      if (wr_res) m_result = W'(r);
      if (wr_flags) m_flags = {r >= HALF, r == 0, c, v};
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return W'(HALF);
      4:       return W'(HALF - 1);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] pick_single();
    int k;
    k = $urandom_range(0, 15);
    if (k < 7) return 5'(k);
    if (k < 15) return 5'(k + 3);
    return 5'($urandom_range(18, 31));
  endfunction

  // Accept one op, scramble the operands afterwards, then wait (bounded) for done.
  // lat counts edges after the accept edge up to the one that raised done.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [OBS_W-1:0] obs);
    @(negedge clk);
    start    = 1'b1;
    alu_op   = op;
    operandA = a;
    operandB = b;
    @(negedge clk);
    start    = 1'b0;
    alu_op   = 5'($urandom);
    operandA = W'($urandom);
    operandB = W'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    obs = {err, result, address, flags};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, err, result, address, flags} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got %h, expected 0", {busy, done, err, result, address, flags});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[$];
    int lat;
    logic [OBS_W-1:0] obs;
    v.push_back('{5'h00, 16'h7FFF, 16'h0001, 16'h8000, 2'b00, 4'b1001, 1'b0, 8'd0});
    v.push_back('{5'h01, 16'h0003, 16'h0005, 16'hFFFE, 2'b00, 4'b1010, 1'b0, 8'd0});
    v.push_back('{5'h0E, 16'h0005, 16'h0005, 16'hFFFE, 2'b00, 4'b0100, 1'b0, 8'd0});
    v.push_back('{5'h04, 16'h0002, 16'h1234, 16'h1234, 2'b10, 4'b0100, 1'b0, 8'd0});
    v.push_back('{5'h06, 16'h8001, 16'h0001, 16'h0003, 2'b10, 4'b0000, 1'b0, 8'd0});
    v.push_back('{5'h02, 16'hFFFF, 16'h0010, 16'h0000, 2'b10, 4'b0100, 1'b0, 8'd0});
    v.push_back('{5'h0F, 16'hF0F0, 16'h0F0F, 16'h0000, 2'b10, 4'b0100, 1'b0, 8'd0});
    v.push_back('{5'h10, 16'hFFFF, 16'h5555, 16'h0000, 2'b10, 4'b0110, 1'b0, 8'd0});
    v.push_back('{5'h11, 16'h8000, 16'h5555, 16'h7FFF, 2'b10, 4'b0001, 1'b0, 8'd0});
`ifdef ALU_SEQ_MULDIV_EN
    v.push_back('{5'h07, 16'h0100, 16'h0100, 16'h0000, 2'b10, 4'b0110, 1'b0, 8'd17});
    v.push_back('{5'h08, 16'h0064, 16'h0007, 16'h000E, 2'b10, 4'b0000, 1'b0, 8'd17});
    v.push_back('{5'h09, 16'h0064, 16'h0007, 16'h0002, 2'b10, 4'b0000, 1'b0, 8'd17});
    v.push_back('{5'h08, 16'h1234, 16'h0000, 16'hFFFF, 2'b10, 4'b1000, 1'b1, 8'd17});
    v.push_back('{5'h09, 16'h1234, 16'h0000, 16'h1234, 2'b10, 4'b0000, 1'b1, 8'd17});
    v.push_back('{5'h12, 16'h0001, 16'h0001, 16'h1234, 2'b10, 4'b0000, 1'b1, 8'd0});
`else
    v.push_back('{5'h07, 16'h0100, 16'h0100, 16'h7FFF, 2'b10, 4'b0001, 1'b1, 8'd0});
    v.push_back('{5'h08, 16'h0064, 16'h0007, 16'h7FFF, 2'b10, 4'b0001, 1'b1, 8'd0});
    v.push_back('{5'h09, 16'h0064, 16'h0000, 16'h7FFF, 2'b10, 4'b0001, 1'b1, 8'd0});
    v.push_back('{5'h12, 16'h0001, 16'h0001, 16'h7FFF, 2'b10, 4'b0001, 1'b1, 8'd0});
`endif
    foreach (v[i]) begin
      model(v[i].op, v[i].a, v[i].b);
      issue(v[i].op, v[i].a, v[i].b, lat, obs);
      n_checks++;
      if (lat != int'(v[i].lat)) begin
        n_errors++;
        $display("FAIL dir_latency[%0d] op=%h: got %0d, expected %0d", i, v[i].op, lat, v[i].lat);
      end
      n_checks++;
      if (obs !== {v[i].e, v[i].res, v[i].addr, v[i].fl}) begin
        n_errors++;
        $display("FAIL dir_outputs[%0d] op=%h: got err/res/addr/flags %h, expected %h",
                 i, v[i].op, obs, {v[i].e, v[i].res, v[i].addr, v[i].fl});
      end
      @(negedge clk);
      n_checks++;
      if ({done, err} !== 2'b00) begin
        n_errors++;
        $display("FAIL dir_done_pulse[%0d]: got done/err %b, expected 00", i, {done, err});
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [OBS_W-1:0] obs;
    logic [4:0] op;
    logic [W-1:0] a, b;
    int k;
    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 21);
      op = (k < 18) ? 5'(k) : 5'($urandom_range(18, 31));
      a  = rnd_val();
      if ((op == 5'h02 || op == 5'h03 || op == 5'h05 || op == 5'h06) && $urandom_range(0, 3) != 0)
        b = W'($urandom_range(0, W + 2));
      else
        b = rnd_val();
      model(op, a, b);
      issue(op, a, b, lat, obs);
      n_checks++;
      if (lat != m_lat || obs !== {m_err, m_result, m_addr, m_flags}) begin
        n_errors++;
        $display("FAIL rand[%0d] op=%h a=%h b=%h: got lat %0d obs %h, expected lat %0d obs %h",
                 i, op, a, b, lat, obs, m_lat, {m_err, m_result, m_addr, m_flags});
      end
    end
  endtask

  task automatic test_busy_ignore();
`ifdef ALU_SEQ_MULDIV_EN
    int busy_cycles;
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    model(5'h07, a, b);
    @(negedge clk);
    start = 1'b1; alu_op = 5'h07; operandA = a; operandB = b;
    @(negedge clk);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < LAT_LIMIT) begin
      busy_cycles++;
      start    = 1'b1;
      alu_op   = 5'($urandom_range(0, 17));
      operandA = W'($urandom);
      operandB = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (busy_cycles != W + 1) begin
      n_errors++;
      $display("FAIL busy_length: got %0d cycles, expected %0d", busy_cycles, W + 1);
    end
    n_checks++;
    if ({done, err, result, address, flags} !== {1'b1, 1'b0, m_result, m_addr, m_flags}) begin
      n_errors++;
      $display("FAIL busy_result: got %h, expected %h",
               {done, err, result, address, flags}, {1'b1, 1'b0, m_result, m_addr, m_flags});
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, result, address, flags} !== {1'b0, 1'b0, m_result, m_addr, m_flags}) begin
      n_errors++;
      $display("FAIL busy_ignored_start: got %h, expected %h",
               {busy, done, result, address, flags}, {1'b0, 1'b0, m_result, m_addr, m_flags});
    end
`else
    int lat;
    logic [OBS_W-1:0] obs;
    model(5'h07, 16'h0100, 16'h0100);
    issue(5'h07, 16'h0100, 16'h0100, lat, obs);
    n_checks++;
    if (busy !== 1'b0 || lat != 0 || obs !== {1'b1, m_result, m_addr, m_flags}) begin
      n_errors++;
      $display("FAIL mul_disabled: got busy %b lat %0d obs %h, expected busy 0 lat 0 obs %h",
               busy, lat, obs, {1'b1, m_result, m_addr, m_flags});
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    logic [W-1:0] a, b;
    op = pick_single(); a = rnd_val(); b = rnd_val();
    @(negedge clk);
    start = 1'b1; alu_op = op; operandA = a; operandB = b;
    model(op, a, b);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if ({done, err, result, address, flags} !== {1'b1, m_err, m_result, m_addr, m_flags}) begin
        n_errors++;
        $display("FAIL b2b[%0d] op=%h: got %h, expected %h", i, op,
                 {done, err, result, address, flags}, {1'b1, m_err, m_result, m_addr, m_flags});
      end
      if (i < 29) begin
        op = pick_single(); a = rnd_val(); b = rnd_val();
        alu_op = op; operandA = a; operandB = b;
        model(op, a, b);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
`ifdef ALU_SEQ_MULDIV_EN
    @(negedge clk);
    start = 1'b1; alu_op = 5'h08; operandA = 16'hBEEF; operandB = 16'h0013;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_div_busy: got %b, expected 1", busy);
    end
`else
    int lat;
    logic [OBS_W-1:0] obs;
    issue(5'h00, 16'h1234, 16'h1111, lat, obs);
`endif
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, result, address, flags} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_values: got %h, expected 0", {busy, done, err, result, address, flags});
    end
    m_result = '0; m_addr = '0; m_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || {busy, result, address, flags} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_no_done: got %0d done cycles, outputs %h, expected 0 and 0",
               done_seen, {busy, result, address, flags});
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
